// File: rtl/fft_pkg.sv
// Shared constants, write-side state encoding and the bit-reversal helper
// for the 16-point FFT input path.
package fft_pkg;

  localparam int FFT_N     = 16;
  localparam int FFT_LOG2N = 4;
  localparam int FFT_DW    = 16;

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } wr_state_e;

  function automatic logic [FFT_LOG2N-1:0] bitrev4(input logic [FFT_LOG2N-1:0] k);
    return {k[0], k[1], k[2], k[3]};
  endfunction

endpackage

// File: rtl/fft_input_loader_if.sv
// Complex-sample valid/ready stream feeding the FFT input loader.
interface fft_input_loader_if #(
  parameter int DW = 16
);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_re;
  logic [DW-1:0] in_im;

  modport master (output in_valid, output in_re, output in_im, input in_ready);
  modport slave  (input in_valid, input in_re, input in_im, output in_ready);
endinterface

// File: rtl/fft_frame_bank.sv
// One 16-entry complex register bank: single write port, synchronous clear,
// every slot visible at once on the flattened outputs.
module fft_frame_bank
  import fft_pkg::*;
#(
  parameter int DW = FFT_DW
) (
  input  logic                 clk_i,
  input  logic                 clr_i,
  input  logic                 we_i,
  input  logic [FFT_LOG2N-1:0] waddr_i,
  input  logic [DW-1:0]        wre_i,
  input  logic [DW-1:0]        wim_i,
  output logic [FFT_N*DW-1:0]  re_o,
  output logic [FFT_N*DW-1:0]  im_o
);

  logic [DW-1:0] re_q [FFT_N];
  logic [DW-1:0] im_q [FFT_N];

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      for (int i = 0; i < FFT_N; i++) begin
        re_q[i] <= '0;
        im_q[i] <= '0;
      end
    end else if (we_i) begin
      re_q[waddr_i] <= wre_i;
      im_q[waddr_i] <= wim_i;
    end
  end

  for (genvar g = 0; g < FFT_N; g++) begin : g_pack
    assign re_o[g*DW +: DW] = re_q[g];
    assign im_o[g*DW +: DW] = im_q[g];
  end

endmodule

// File: rtl/fft_input_loader.sv
// Ping-pong frame loader: fills one bank in bit-reversed order while the other is presented.
// Frame visible 1 cycle after the 16th accept; in_ready drops while a full bank waits for a read.
module fft_input_loader
  import fft_pkg::*;
#(
  parameter int N      = FFT_N,
  parameter int DW     = FFT_DW,
  parameter bit BITREV = 1'b1
) (
  input  logic                CLK,
  input  logic                RST,
  fft_input_loader_if.slave   in_s,
  input  logic                RD_en,
  output logic [N*DW-1:0]     frame_re,
  output logic [N*DW-1:0]     frame_im,
  output logic                frame_valid,
  output logic [7:0]          underrun_cnt
);

  wr_state_e            state_q, state_d;
  logic [FFT_LOG2N-1:0] wr_cnt_q, wr_cnt_d;
  logic                 bank_ptr_q, bank_ptr_d;
  logic                 frame_valid_q, frame_valid_d;
  logic [7:0]           underrun_q, underrun_d;

  logic                 accept, wrap, full_now, swap;
  logic [FFT_LOG2N-1:0] wr_addr;
  logic [N*DW-1:0]      b0_re, b0_im, b1_re, b1_im;

  assign in_s.in_ready = (state_q == FILL);
  assign accept        = in_s.in_valid && (state_q == FILL);
  assign wrap          = accept && (wr_cnt_q == '1);
  // A bank completing on this very edge may swap straight away.
  assign full_now      = (state_q == FULL) || wrap;
  assign swap          = full_now && (!frame_valid_q || RD_en);
  assign wr_addr       = BITREV ? bitrev4(wr_cnt_q) : wr_cnt_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q       <= FILL;
      wr_cnt_q      <= '0;
      bank_ptr_q    <= 1'b0;
      frame_valid_q <= 1'b0;
      underrun_q    <= '0;
    end else begin
      state_q       <= state_d;
      wr_cnt_q      <= wr_cnt_d;
      bank_ptr_q    <= bank_ptr_d;
      frame_valid_q <= frame_valid_d;
      underrun_q    <= underrun_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    wr_cnt_d      = wr_cnt_q;
    bank_ptr_d    = bank_ptr_q;
    frame_valid_d = frame_valid_q;
    underrun_d    = underrun_q;

    if (accept) begin
      wr_cnt_d = wr_cnt_q + FFT_LOG2N'(1);
    end

    case (state_q)
      FILL:    if (wrap && !swap) state_d = FULL;
      FULL:    if (swap)          state_d = FILL;
      default:                    state_d = FILL;
    endcase

    if (swap) begin
      bank_ptr_d    = ~bank_ptr_q;
      frame_valid_d = 1'b1;
    end else if (RD_en) begin
      frame_valid_d = 1'b0;
    end

    if (RD_en && !frame_valid_q && (underrun_q != 8'hFF)) begin
      underrun_d = underrun_q + 8'd1;
    end
  end

  // bank_ptr_q names the presented bank; writes always go to the other one.
  fft_frame_bank #(.DW(DW)) u_bank0 (
    .clk_i   (CLK),
    .clr_i   (RST),
    .we_i    (accept && bank_ptr_q),
    .waddr_i (wr_addr),
    .wre_i   (in_s.in_re),
    .wim_i   (in_s.in_im),
    .re_o    (b0_re),
    .im_o    (b0_im)
  );

  fft_frame_bank #(.DW(DW)) u_bank1 (
    .clk_i   (CLK),
    .clr_i   (RST),
    .we_i    (accept && !bank_ptr_q),
    .waddr_i (wr_addr),
    .wre_i   (in_s.in_re),
    .wim_i   (in_s.in_im),
    .re_o    (b1_re),
    .im_o    (b1_im)
  );

  assign frame_re     = bank_ptr_q ? b1_re : b0_re;
  assign frame_im     = bank_ptr_q ? b1_im : b0_im;
  assign frame_valid  = frame_valid_q;
  assign underrun_cnt = underrun_q;

endmodule
